mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Two-requester round-robin arbiter that owns the shared 2:1 data selector and decides, cycle by cycle, which requester drives the shared output line. It sits between two independent bit sources and the single downstream consumer. It sequences the select line of a `mux2_1` instance and gates the result so the line reads 0 when no one holds it. A hold-limit counter guarantees fairness: no requester can starve the other.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive granted cycles while the other requester waits. Legal range is 2..256.
- `clk  input  1`: system clock. All state updates on the rising edge.
- `reset  input  1`: asynchronous, active-high reset.
- `req  input  2`: request lines; bit 0 is requester 0, bit 1 is requester 1.
- `din  input  2`: data bits; `din[0]` is from requester 0, `din[1]` is from requester 1.
- `gnt  output  2`: one-hot grant, registered. The value 2'b11 never occurs.
- `sel  output  1`: registered select for the shared mux; 1 means requester 1.
- `busy  output  1`: registered; equals `|gnt`.
- `out  output  1`: shared line. Equals `din[sel] & busy`; combinational from `din`.

## Operation
- States: IDLE, G0, G1. The state is the only thing that drives `gnt`, `sel` and `busy`.
- `last` register records the requester most recently granted. It is used only to break ties.
- `hold` counter has width `$clog2(MAX_HOLD)`. It counts cycles in the current grant and saturates at `MAX_HOLD-1`.
- IDLE transitions:
  - `req==2'b00` → stay in IDLE.
  - Only `req[0]` asserted → G0.
  - Only `req[1]` asserted → G1.
  - Both asserted → grant the requester that is not `last`.
- G0 transitions (G1 is symmetric):
  - `req[0]` high and (`req[1]` low or `hold < MAX_HOLD-1`) → stay in G0, `hold` increments.
  - `req[0]` high, `req[1]` high and `hold == MAX_HOLD-1` → G1. This is a forced handoff; `hold` clears.
  - `req[0]` low and `req[1]` high → G1. Direct handoff with no IDLE bubble; `hold` clears.
  - `req[0]` low and `req[1]` low → IDLE; `hold` clears.
- `last` updates on every entry into G0 or G1.
- `sel` holds its value in IDLE, so the mux input stays stable.
- Sole holder with no competitor: the grant is kept indefinitely and `hold` stays saturated, with no spurious release.
- Forced handoff: the preempted requester, if it is still requesting, is next in line. It regains the grant after the other side drops its request or reaches the hold limit.

## Timing
- Latency from request to grant: `req` sampled high at edge N → `gnt` high after edge N. The first granted data appears on `out` in the same cycle.
- Release latency: `req` sampled low at edge N → `gnt` deasserts or switches after edge N.
- A requester must keep `req` high until it is done. Dropping `req` for one cycle forfeits the grant.
- Maximum wait for a requesting side, once the other is granted: `MAX_HOLD` cycles.
- Reset mid-grant forces the reset values immediately, asynchronously. `out` goes to 0 in the same instant.
- Reset values:
  - State is IDLE.
  - `gnt=2'b00`, `sel=0`, `busy=0`.
  - `hold=0`.
  - `last=1`, so requester 0 wins the first tie.
  - `out=0`.
- No combinational path from `req` to any output. `out` depends combinationally only on `din` and registered state.

## Structure
- Package `mux2_arbiter_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, G0, G1} arb_state_t`.
  - Grant encodings `GNT_NONE`, `GNT0`, `GNT1`.
- One sub-module: `mux2_1`, instantiated once with `i0=din[0]`, `i1=din[1]` and `sel`. Its output is ANDed with `busy` to form `out`.
- Next-state logic and the counter live in separate always blocks. All state is in one `always_ff` with asynchronous reset.

## Test plan
- Reset check: assert `reset` mid-cycle while in G1. Required: `gnt=00`, `sel=0`, `busy=0`, `out=0` immediately. After reset is released with `req=11`, the first grant is `gnt=01`.
- Single requester: `req=01`, `din=01` for 20 cycles. Required: `gnt=01` from the cycle after `req` is first sampled; `out=1` throughout; no handoff.
- Tie rotation: `req=11` from IDLE twice, with `req=00` for one cycle in between. Required: the first grant goes to requester 0 and the second goes to requester 1.
- Hold limit with `MAX_HOLD=4`: `req=11` held steady. Required: grant alternates 01,01,01,01,10,10,10,10,01,… and `out` tracks `din[sel]`.
- Direct handoff: in G0, `req` goes 11 → 10. Required: `gnt` goes 01 → 10 on the next edge with no IDLE cycle, and `sel=1`.
- Idle gating: `req=00` with `din=11`. Required: `out=0`, `busy=0`, and `sel` keeps its previous value.

Source files
------------

// File: rtl/mux2_arbiter_pkg.sv
// Shared types and grant encodings for the two-requester round-robin arbiter.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, G0, G1} arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT0     = 2'b01;
    localparam logic [1:0] GNT1     = 2'b10;

    function automatic logic [1:0] gnt_of(arb_state_t s);
        case (s)
            G0:      return GNT0;
            G1:      return GNT1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// Request/data/grant bundle between the two requesters, the arbiter and the consumer.
interface mux2_arbiter_if;
    logic [1:0] req;
    logic [1:0] din;
    logic [1:0] gnt;
    logic       sel;
    logic       busy;
    logic       out;

    modport master (output req, din, input gnt, sel, busy, out);
    modport slave  (input req, din, output gnt, sel, busy, out);
endinterface

// File: rtl/mux2_arbiter_mux2_1.sv
// Plain 2:1 bit selector driven by the arbiter's registered select.
module mux2_1 (
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic o
);
    assign o = sel ? i1 : i0;
endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for two bit sources sharing one line, with a hold limit
// that forces a handoff so neither requester can starve the other.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           reset,
    mux2_arbiter_if.slave  bus
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    arb_state_t    state, state_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          last;
    logic [1:0]    gnt_q;
    logic          sel_q, busy_q;
    logic          mux_o;

    // last==1 means requester 1 won most recently, so requester 0 takes the tie.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                case (bus.req)
                    2'b01:   state_nxt = G0;
                    2'b10:   state_nxt = G1;
                    2'b11:   state_nxt = last ? G0 : G1;
                    default: state_nxt = IDLE;
                endcase
            end
            G0: begin
                if (bus.req[0] && (!bus.req[1] || hold != HOLD_MAX)) state_nxt = G0;
                else if (bus.req[1])                                 state_nxt = G1;
                else                                                 state_nxt = IDLE;
            end
            G1: begin
                if (bus.req[1] && (!bus.req[0] || hold != HOLD_MAX)) state_nxt = G1;
                else if (bus.req[0])                                 state_nxt = G0;
                else                                                 state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on any grant change and saturates while the holder stays.
    always_comb begin
        hold_nxt = '0;
        if (state_nxt == state && state != IDLE)
            hold_nxt = (hold == HOLD_MAX) ? hold : hold + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            hold   <= '0;
            last   <= 1'b1;
            gnt_q  <= GNT_NONE;
            sel_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            hold   <= hold_nxt;
            gnt_q  <= gnt_of(state_nxt);
            busy_q <= (state_nxt != IDLE);
            // sel keeps its value through IDLE so the mux input stays stable
            if (state_nxt == G0) begin
                sel_q <= 1'b0;
                last  <= 1'b0;
            end else if (state_nxt == G1) begin
                sel_q <= 1'b1;
                last  <= 1'b1;
            end
        end
    end

    mux2_1 u_mux (
        .i0  (bus.din[0]),
        .i1  (bus.din[1]),
        .sel (sel_q),
        .o   (mux_o)
    );

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.out  = mux_o & busy_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter with MAX_HOLD=4; inputs change on negedge, outputs checked on negedge.
module tb_mux2_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mux2_arbiter_if bus();

    mux2_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        bus.req = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req = 2'b00; bus.din = 2'b11;
        do_reset();
        checks++;
        if (bus.gnt !== 2'b00 || bus.sel !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: gnt=%b sel=%b busy=%b out=%b, required 00 0 0 0",
                     bus.gnt, bus.sel, bus.busy, bus.out);
        end
        bus.req = 2'b10;
        step();
        checks++;
        if (bus.gnt !== 2'b10 || bus.sel !== 1'b1 || bus.out !== 1'b1) begin
            errors++;
            $display("FAIL reset_enter_g1: gnt=%b sel=%b out=%b, required 10 1 1", bus.gnt, bus.sel, bus.out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== 2'b00 || bus.sel !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: gnt=%b sel=%b busy=%b out=%b, required 00 0 0 0",
                     bus.gnt, bus.sel, bus.busy, bus.out);
        end
        @(negedge clk);
        bus.req = 2'b11;
        reset = 1'b0;
        step();
        checks++;
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_tie: gnt=%b, required 01", bus.gnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 2'b01; bus.din = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.gnt !== 2'b01 || bus.out !== 1'b1) begin
                errors++;
                $display("FAIL single_cycle%0d: gnt=%b out=%b, required 01 1", i, bus.gnt, bus.out);
            end
        end
        // out follows din with no clock edge
        bus.din = 2'b10;
        #1;
        checks++;
        if (bus.out !== 1'b0) begin
            errors++;
            $display("FAIL single_out_comb: out=%b, required 0", bus.out);
        end
    endtask

    task automatic test_saturated_handoff();
        // requester 0 has held well past the limit alone; a competitor gets it next edge
        bus.req = 2'b11;
        step();
        checks++;
        if (bus.gnt !== 2'b10 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL sat_handoff: gnt=%b sel=%b, required 10 1", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_tie_rotation();
        do_reset();
        bus.req = 2'b11;
        step();
        checks++;
        if (bus.gnt !== 2'b01) begin
            errors++;
            $display("FAIL tie_first: gnt=%b, required 01", bus.gnt);
        end
        bus.req = 2'b00;
        step();
        checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: gnt=%b busy=%b, required 00 0", bus.gnt, bus.busy);
        end
        bus.req = 2'b11;
        step();
        checks++;
        if (bus.gnt !== 2'b10) begin
            errors++;
            $display("FAIL tie_second: gnt=%b, required 10", bus.gnt);
        end
    endtask

    task automatic test_hold_limit();
        logic [1:0] exp_gnt;
        logic       exp_out;
        do_reset();
        bus.req = 2'b11; bus.din = 2'b01;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_gnt = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
            exp_out = (exp_gnt == 2'b01) ? 1'b1 : 1'b0;
            checks++;
            if (bus.gnt !== exp_gnt || bus.out !== exp_out) begin
                errors++;
                $display("FAIL hold_cycle%0d: gnt=%b out=%b, required %b %b",
                         i, bus.gnt, bus.out, exp_gnt, exp_out);
            end
        end
    endtask

    task automatic test_direct_handoff();
        do_reset();
        bus.req = 2'b11; bus.din = 2'b10;
        step();
        checks++;
        if (bus.gnt !== 2'b01 || bus.out !== 1'b0) begin
            errors++;
            $display("FAIL handoff_g0: gnt=%b out=%b, required 01 0", bus.gnt, bus.out);
        end
        bus.req = 2'b10;
        step();
        checks++;
        if (bus.gnt !== 2'b10 || bus.sel !== 1'b1 || bus.busy !== 1'b1 || bus.out !== 1'b1) begin
            errors++;
            $display("FAIL handoff_g1: gnt=%b sel=%b busy=%b out=%b, required 10 1 1 1",
                     bus.gnt, bus.sel, bus.busy, bus.out);
        end
    endtask

    task automatic test_idle_gating();
        // entered from G1, so sel must stay 1
        bus.req = 2'b00; bus.din = 2'b11;
        step();
        checks++;
        if (bus.out !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 1'b1 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL idle_gate: out=%b busy=%b sel=%b gnt=%b, required 0 0 1 00",
                     bus.out, bus.busy, bus.sel, bus.gnt);
        end
        step();
        checks++;
        if (bus.out !== 1'b0 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: out=%b sel=%b, required 0 1", bus.out, bus.sel);
        end
    endtask

    initial begin
        bus.req = 2'b00;
        bus.din = 2'b00;
        test_reset();
        test_single();
        test_saturated_handoff();
        test_tie_rotation();
        test_hold_limit();
        test_direct_handoff();
        test_idle_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
